// File: rtl/clk_sched_pkg.sv
// clk_sched_pkg
//   Shared definitions for the clock-enable scheduler:
//   - DEF_CNT_W / DEF_DIV_VAL : default counter width and reset divisor
//   - sched_state_e           : config FSM states
//   - sq_high()               : square-wave "second half of period" compare
package clk_sched_pkg;

    localparam int                   DEF_CNT_W   = 28;
    localparam logic [DEF_CNT_W-1:0] DEF_DIV_VAL = 28'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } sched_state_e;

    // High once the counter reaches the integer half of the divisor.
    // Widened to 64 bits so any channel width up to 64 can share it.
    function automatic logic sq_high(input logic [63:0] cnt, input logic [63:0] div);
        return cnt >= (div >> 1);
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan
//   One tick channel: enable, divisor and counter registers plus the
//   tick / square decode.
//   Ports:
//     clk_i, rst_ni    clock, synchronous active-low reset
//     commit_i         load commit_en_i/commit_div_i, zero the counter
//     commit_en_i      new enable (0 keeps the old divisor)
//     commit_div_i     new divisor
//     sync_i           zero the counter if enabled
//     en_o             current enable
//     wrap_o           counter is in its last cycle of the period
//     tick_o, sq_o     one-cycle enable tick, 50% square output
module clk_en_chan
    import clk_sched_pkg::*;
#(
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_VAL)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             commit_i,
    input  logic             commit_en_i,
    input  logic [CNT_W-1:0] commit_div_i,
    input  logic             sync_i,
    output logic             en_o,
    output logic             wrap_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic             en_q, en_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last;
    logic             wrap;

    assign last = div_q - CNT_W'(1);
    // >= rather than == so an out-of-range count folds back to 0
    assign wrap = cnt_q >= last;

    always_comb begin
        en_d  = en_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (commit_i) begin
            en_d  = commit_en_i;
            if (commit_en_i) div_d = commit_div_i;
            cnt_d = '0;
        end else if (!en_q || sync_i || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en_q  <= 1'b1;
            div_q <= DEF_DIV;
            cnt_q <= '0;
        end else begin
            en_q  <= en_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // Pure register decode: no path from any input to these outputs.
    assign en_o   = en_q;
    assign wrap_o = wrap;
    assign tick_o = en_q & (cnt_q == last);
    assign sq_o   = en_q & sq_high(64'(cnt_q), 64'(div_q));

endmodule

// File: rtl/clk_en_sched.sv
// clk_en_sched
//   Multi-channel clock-enable scheduler. Each channel produces a
//   one-cycle tick and a 50% square output at its own divisor. Divisor
//   and enable changes come in through a valid/ready config port and
//   commit at the target channel's next wrap so no period is truncated.
//   Ports:
//     clk_i, rst_ni                 clock, synchronous active-low reset
//     cfg_valid_i / cfg_ready_o     config handshake
//     cfg_ch_i, cfg_div_i, cfg_en_i config request fields
//     cfg_done_o                    pulse when the pending request commits
//     cfg_err_o                     pulse when an accepted request is rejected
//     sync_i                        zero all enabled channel counters
//     tick_o, sq_o                  per-channel tick and square outputs
module clk_en_sched
    import clk_sched_pkg::*;
#(
    parameter int               NUM_CH  = 4,
    parameter int               CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_VAL),
    localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    input  logic              cfg_en_i,
    output logic              cfg_done_o,
    output logic              cfg_err_o,
    input  logic              sync_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] sq_o
);

    sched_state_e     state_q, state_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_en_q, pend_en_d;

    logic [NUM_CH-1:0] chan_en, chan_wrap, chan_commit;
    logic              commit_fire;
    logic              req_bad;

    // Commit immediately when no running period needs protecting,
    // otherwise wait for the target's wrap cycle.
    assign commit_fire = (state_q == ST_PEND) &&
                         (!chan_en[pend_ch_q] || !pend_en_q || chan_wrap[pend_ch_q]);

    assign req_bad = (cfg_en_i && (cfg_div_i == '0)) ||
                     ({1'b0, cfg_ch_i} >= (CH_W+1)'(NUM_CH));

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        pend_en_d  = pend_en_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i && ready_q) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ST_PEND;
                        ready_d    = 1'b0;
                        pend_ch_d  = cfg_ch_i;
                        pend_div_d = cfg_div_i;
                        pend_en_d  = cfg_en_i;
                    end
                end
            end
            ST_PEND: begin
                if (commit_fire) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            pend_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
            pend_en_q  <= pend_en_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign cfg_done_o  = done_q;
    assign cfg_err_o   = err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
        assign chan_commit[c] = commit_fire && (pend_ch_q == CH_W'(c));

        clk_en_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .commit_i     (chan_commit[c]),
            .commit_en_i  (pend_en_q),
            .commit_div_i (pend_div_q),
            .sync_i       (sync_i),
            .en_o         (chan_en[c]),
            .wrap_o       (chan_wrap[c]),
            .tick_o       (tick_o[c]),
            .sq_o         (sq_o[c])
        );
    end

endmodule

// File: tb/tb_clk_en_sched.sv
// tb_clk_en_sched
//   Directed scenarios followed by random traffic. The reference model
//   tracks, per channel, the cycle at which its count last restarted;
//   the count is then (now - start) mod div, and ticks / square levels
//   and commit timing follow from that arithmetic.
module tb_clk_en_sched;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 28;
    localparam int CH_W   = 3;
    localparam int DEFDIV = 2;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              cfg_valid_i = 1'b0;
    logic              cfg_ready_o;
    logic [CH_W-1:0]   cfg_ch_i = '0;
    logic [CNT_W-1:0]  cfg_div_i = '0;
    logic              cfg_en_i = 1'b0;
    logic              cfg_done_o;
    logic              cfg_err_o;
    logic              sync_i = 1'b0;
    logic [NUM_CH-1:0] tick_o;
    logic [NUM_CH-1:0] sq_o;

    clk_en_sched #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (28'd2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_en_i    (cfg_en_i),
        .cfg_done_o  (cfg_done_o),
        .cfg_err_o   (cfg_err_o),
        .sync_i      (sync_i),
        .tick_o      (tick_o),
        .sq_o        (sq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    int n = 0;
    bit m_en [NUM_CH];
    int m_div[NUM_CH];
    int m_t0 [NUM_CH];
    bit m_pend, m_ready, m_done, m_err;
    int p_ch, p_div;
    bit p_en;

    function automatic int mcnt(int c);
        return (n - m_t0[c]) % m_div[c];
    endfunction

    // Advance the model across one rising edge using the driven inputs.
    task automatic model_edge();
        bit commit;
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_en[c] = 1'b1; m_div[c] = DEFDIV; m_t0[c] = n + 1;
            end
            m_pend = 0; m_ready = 1; m_done = 0; m_err = 0;
        end else begin
            commit = m_pend && (!m_en[p_ch] || !p_en || mcnt(p_ch) == m_div[p_ch] - 1);
            m_done = commit;
            m_err  = 0;
            if (commit) begin
                m_en[p_ch] = p_en;
                if (p_en) m_div[p_ch] = p_div;
                m_t0[p_ch] = n + 1;
                m_pend = 0;
            end else if (!m_pend && m_ready && cfg_valid_i) begin
                if ((cfg_en_i && cfg_div_i == 0) || int'(cfg_ch_i) >= NUM_CH) begin
                    m_err = 1;
                end else begin
                    m_pend = 1;
                    p_ch = int'(cfg_ch_i); p_div = int'(cfg_div_i); p_en = cfg_en_i;
                end
            end
            if (sync_i)
                for (int c = 0; c < NUM_CH; c++)
                    if (m_en[c]) m_t0[c] = n + 1;
            m_ready = !m_pend;
        end
        n++;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, n);
        end
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] et, es;
        for (int c = 0; c < NUM_CH; c++) begin
            et[c] = m_en[c] && (mcnt(c) == m_div[c] - 1);
            es[c] = m_en[c] && (mcnt(c) >= m_div[c] / 2);
        end
        chk("tick",  32'(tick_o), 32'(et));
        chk("sq",    32'(sq_o),   32'(es));
        chk("ready", 32'(cfg_ready_o), 32'(m_ready));
        chk("done",  32'(cfg_done_o),  32'(m_done));
        chk("err",   32'(cfg_err_o),   32'(m_err));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Hold a request until the DUT takes it; bounded wait.
    task automatic req(int ch, int dv, bit en);
        bit acc = 0;
        cfg_valid_i = 1'b1;
        cfg_ch_i    = CH_W'(ch);
        cfg_div_i   = CNT_W'(dv);
        cfg_en_i    = en;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = cfg_ready_o;
            step();
        end
        cfg_valid_i = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $error("FAIL req_timeout got=busy exp=accepted ch=%0d", ch);
        end
    endtask

    task automatic do_reset(int k);
        rst_ni = 1'b0;
        run(k);
        rst_ni = 1'b1;
    endtask

    initial begin
        // reset, default divisor on all channels
        do_reset(2);
        run(8);

        // rate change ch1 2 -> 5 while running
        req(1, 5, 1);
        run(12);

        // disable ch2, then re-enable at div 3
        req(2, 0, 0);
        run(5);
        req(2, 3, 1);
        run(8);

        // rejected requests: zero divisor, out-of-range channels
        req(0, 0, 1);
        run(2);
        req(5, 7, 1);
        run(1);
        req(7, 3, 1);
        run(4);

        // out-of-phase ch0/ch3, then phase align
        req(0, 4, 1);
        run(1);
        req(3, 6, 1);
        run(3);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        run(14);

        // reset while a request is pending
        req(1, 7, 1);
        run(1);
        do_reset(1);
        run(10);

        // random traffic
        for (int it = 0; it < 700; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                req(int'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9)),
                    $urandom_range(0, 3) != 0);
            end else if (r == 99) begin
                do_reset(1);
            end else begin
                sync_i = ($urandom_range(0, 19) == 0);
                step();
                sync_i = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
